// File: rtl/tone_gen.sv
// tone_gen: button-to-DAC tone front end on a single clock.
//   Synchronizes and debounces the four note buttons, picks the sounding
//   note by priority (C > D > E > G), emits one-cycle sample strobes at that
//   note's rate, steps the 5-bit sine ROM address and registers the ROM
//   output onto the DAC bus.
// Ports:
//   clk, rst_n        50 MHz clock, asynchronous active-low reset
//   do/re/mi/sol_nota raw asynchronous note buttons (C, D, E, G)
//   octave_up         raw octave button (only with OCTAVE_UP_EN)
//   rom_data          combinational sine ROM output for sample_addr
//   sample_addr       sine ROM address
//   sample_stb        one-cycle pulse in the cycle sample_addr advances
//   note_active       high while a note plays or finishes its release
//   note_id           sounding note: 0=C, 1=D, 2=E, 3=G
//   tono              registered sample to the DAC (SILENCE when quiet)
// Optional feature macro: OCTAVE_UP_EN (octave_up button doubles the rate).
module tone_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DIV_DO          = 2986,
  parameter int unsigned DIV_RE          = 2660,
  parameter int unsigned DIV_MI          = 2369,
  parameter int unsigned DIV_SOL         = 1993,
  parameter logic [3:0]  SILENCE         = 4'h8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       do_nota,
  input  logic       re_nota,
  input  logic       mi_nota,
  input  logic       sol_nota,
`ifdef OCTAVE_UP_EN
  input  logic       octave_up,
`endif
  input  logic [3:0] rom_data,
  output logic [4:0] sample_addr,
  output logic       sample_stb,
  output logic       note_active,
  output logic [1:0] note_id,
  output logic [3:0] tono
);

  localparam int unsigned DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIVW = 16;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
`ifdef OCTAVE_UP_EN
  localparam int unsigned NB = 5;
`else
  localparam int unsigned NB = 4;
`endif

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_e;

  logic [NB-1:0]   raw_c, sync1_q, sync2_q, deb_q, deb_d;
  logic [DBW-1:0]  cnt_q [NB];
  logic [DBW-1:0]  cnt_d [NB];
  state_e          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d, div_sel_c, limit_c;
  logic [4:0]      addr_q, addr_d;
  logic [1:0]      note_q, note_d, sel_c;
  logic            stb_q, stb_d, active_q, active_d;
  logic [3:0]      tono_q, tono_d;
  logic            req_c, note_chg_c, oct_chg_c, step_c;

`ifdef OCTAVE_UP_EN
  logic oct_q, oct_d;
  assign raw_c     = {octave_up, sol_nota, mi_nota, re_nota, do_nota};
  assign oct_chg_c = (deb_q[4] != oct_q);
`else
  assign raw_c     = {sol_nota, mi_nota, re_nota, do_nota};
  assign oct_chg_c = 1'b0;
`endif

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + DBW'(1);
      end
    end
  end

  // Priority select among debounced notes.
  always_comb begin
    req_c = |deb_q[3:0];
    if      (deb_q[0]) sel_c = 2'd0;
    else if (deb_q[1]) sel_c = 2'd1;
    else if (deb_q[2]) sel_c = 2'd2;
    else               sel_c = 2'd3;
  end

  // Divider limit follows the note (and octave) currently in effect.
  always_comb begin
    case (note_q)
      2'd0:    div_sel_c = DIVW'(DIV_DO);
      2'd1:    div_sel_c = DIVW'(DIV_RE);
      2'd2:    div_sel_c = DIVW'(DIV_MI);
      default: div_sel_c = DIVW'(DIV_SOL);
    endcase
`ifdef OCTAVE_UP_EN
    limit_c = oct_q ? (div_sel_c - DIVW'(1))
                    : ({div_sel_c[DIVW-2:0], 1'b0} - DIVW'(1));
`else
    limit_c = {div_sel_c[DIVW-2:0], 1'b0} - DIVW'(1);
`endif
  end

  assign note_chg_c = req_c && (sel_c != note_q);

  // Next-state: note changes clear the divider and pre-empt any strobe.
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    div_d   = div_q;
    addr_d  = addr_q;
    stb_d   = 1'b0;
    step_c  = 1'b0;
`ifdef OCTAVE_UP_EN
    oct_d   = oct_q;
`endif
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (req_c) begin
          state_d = PLAY;
          note_d  = sel_c;
`ifdef OCTAVE_UP_EN
          oct_d   = deb_q[4];
`endif
        end
      end
      PLAY: begin
        if (!req_c) state_d = RELEASE;
        step_c = 1'b1;
      end
      RELEASE: begin
        if (req_c) state_d = PLAY;
        step_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (step_c) begin
      if (note_chg_c || oct_chg_c) begin
        div_d = '0;
        if (note_chg_c) note_d = sel_c;
`ifdef OCTAVE_UP_EN
        oct_d = deb_q[4];
`endif
      end else if (div_q == limit_c) begin
        div_d  = '0;
        stb_d  = 1'b1;
        addr_d = addr_q + 5'd1;
        // Release ends exactly on the wrap so the next note starts at address 0.
        if (state_q == RELEASE && !req_c && addr_q == 5'd31) state_d = IDLE;
      end else begin
        div_d = div_q + DIVW'(1);
      end
    end

    active_d = (state_d != IDLE);
    tono_d   = active_q ? rom_data : SILENCE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q    <= '{default: '0};
      state_q  <= IDLE;
      div_q    <= '0;
      addr_q   <= '0;
      note_q   <= '0;
      stb_q    <= 1'b0;
      active_q <= 1'b0;
      tono_q   <= SILENCE;
`ifdef OCTAVE_UP_EN
      oct_q    <= 1'b0;
`endif
    end else begin
      sync1_q  <= raw_c;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      div_q    <= div_d;
      addr_q   <= addr_d;
      note_q   <= note_d;
      stb_q    <= stb_d;
      active_q <= active_d;
      tono_q   <= tono_d;
`ifdef OCTAVE_UP_EN
      oct_q    <= oct_d;
`endif
    end
  end

  assign sample_addr = addr_q;
  assign sample_stb  = stb_q;
  assign note_active = active_q;
  assign note_id     = note_q;
  assign tono        = tono_q;

endmodule
